add_tag: RTL and testbench
==========================

Name: add_tag

Overview:
- Attaches a TAG_WIDTH tag to each untagged DATA_WIDTH token, producing {tag, data}. It is the inverse of del_tag.
- Sits at fabric boundaries where an untagged stream enters a tagged region.
- The tag comes from a runtime-configurable register. Each token captures the tag value current at its acceptance.
- A 2-entry skid buffer gives full throughput with registered ready.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
TAG_WIDTH, 4, tag width in bits (>=1)
DEFAULT_TAG, 0, tag register value after reset

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
cfg_valid  input  1  load cfg_tag into tag register this cycle
cfg_tag  input  TAG_WIDTH  new tag value
in_valid  input  1  upstream token valid
in_ready  output  1  block can accept a token
in_data  input  DATA_WIDTH  untagged payload
out_valid  output  1  tagged token valid
out_ready  input  1  downstream accepts
out_data  output  TAG_WIDTH+DATA_WIDTH  {tag[TAG_WIDTH-1:0], data[DATA_WIDTH-1:0]}, tag in MSBs
tag_q  output  TAG_WIDTH  current tag register value (observability)

Behaviour:
- Reset (synchronous: rst sampled high at a clk edge):
  - tag_q=DEFAULT_TAG; buffer state=EMPTY; out_valid=0; in_ready=1; out_data=0.
  - Reset mid-operation discards all buffered tokens without emitting them. in_valid is ignored while rst=1.
- Handshakes:
  - Input transfer when in_valid&&in_ready at a clk edge. Output transfer when out_valid&&out_ready.
  - out_valid, once high, stays high and out_data stays stable until a transfer occurs (AXI-style).
  - in_ready is a registered function of state only, with no combinational path from out_ready. out_valid/out_data are registered.
- Tag register:
  - On cfg_valid=1, tag_q<=cfg_tag at the next edge.
  - The tag bound to a token is tag_q as sampled in its acceptance cycle. If cfg_valid and an input transfer coincide, the token gets the OLD tag and the new tag applies from the next token on.
  - Tokens already buffered never change tag.
- Storage: main register M (drives out_data) plus skid register S, each TAG_WIDTH+DATA_WIDTH wide.
- States and outputs:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: M valid, out_valid=1, in_ready=1.
  - FULL: M and S valid, out_valid=1, in_ready=0.
- Transitions (in = input transfer, out = output transfer):
  - EMPTY: in -> ONE, M<={tag_q,in_data}.
  - ONE: in&&!out -> FULL, S<=new. in&&out -> ONE, M<=new. !in&&out -> EMPTY. Otherwise hold.
  - FULL: out -> ONE, M<=S. No input transfer is possible while FULL.
- Latency and throughput:
  - Latency is 1 cycle: a token accepted at edge k is on out_data with out_valid=1 after edge k.
  - Sustained throughput is 1 token/cycle when out_ready=1.
- Ordering: strict FIFO order. No token is dropped or duplicated.
- Width rule: out_data = {tag, data} by concatenation. No arithmetic, no truncation.

Test Plan:
- Basic tag insertion: reset with DEFAULT_TAG=0; cfg_valid=1, cfg_tag=4'hA for one cycle; send in_data=32'hDEAD_BEEF with out_ready=1 -> one cycle later out_valid=1 and out_data=36'hA_DEAD_BEEF; tag_q=4'hA.
- Backpressure and skid: out_ready=0, offer 32'h1, 32'h2, 32'h3 back-to-back -> in_ready drops after 2 accepts; raise out_ready -> outputs {A,1}, {A,2}, then 3 is accepted and {A,3} follows, in order, with no loss or duplicates.
- Tag change mid-stream: stream 32'h10..32'h13 with out_ready=1; assert cfg_valid with cfg_tag=4'h5 in the same cycle 32'h12 is accepted -> outputs tagged A, A, A, 5.
- Full throughput: 100 consecutive tokens with out_ready=1 -> 100 outputs in 100 consecutive cycles after the first, out_valid never deasserts mid-stream.
- Reset mid-operation: buffer FULL with out_ready=0; assert rst for 1 cycle -> next cycle out_valid=0, in_ready=1, tag_q=DEFAULT_TAG; neither buffered token ever appears on the output.
- Random stall: random in_valid/out_ready (50%) over 1000 tokens -> scoreboard matches {tag at accept, data} in order; out_data stays stable while out_valid&&!out_ready.

Source files
------------

// File: rtl/add_tag.sv
// Attaches the current tag register value to each untagged token: out = {tag, data}.
// A two-entry skid buffer (main M + skid S) gives full throughput with registered ready.
module add_tag #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TAG_WIDTH   = 4,
  parameter logic [TAG_WIDTH-1:0] DEFAULT_TAG = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_valid,
  input  logic [TAG_WIDTH-1:0]           cfg_tag,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]           tag_q
);

  localparam int unsigned OUT_WIDTH = TAG_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   m_q, m_d;
  logic [OUT_WIDTH-1:0]   s_q, s_d;
  logic [TAG_WIDTH-1:0]   tag_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;

  logic                   in_fire;
  logic                   out_fire;
  logic [OUT_WIDTH-1:0]   new_tok;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;
  // The token binds to the tag held before any coincident cfg write lands.
  assign new_tok  = {tag_q, in_data};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    tag_d   = cfg_valid ? cfg_tag : tag_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          m_d     = new_tok;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && !out_fire) begin
          s_d     = new_tok;
          state_d = ST_FULL;
        end else if (in_fire && out_fire) begin
          m_d     = new_tok;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      tag_q       <= DEFAULT_TAG;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      tag_q       <= tag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = m_q;

endmodule

// File: tb/tb_add_tag.sv
// Directed and random-stall checks for add_tag with a scoreboard of {tag, data}.
module tb_add_tag;

  localparam int DW = 32;
  localparam int TW = 4;
  localparam int OW = DW + TW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic [TW-1:0] cfg_tag;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [TW-1:0] tag_q;

  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  int n_out = 0;

  logic [OW-1:0] sb[$];
  logic [TW-1:0] model_tag;

  add_tag #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEFAULT_TAG(4'h0)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_tag(cfg_tag),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tag_q(tag_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Evaluate handshakes with the inputs currently driven, then advance one edge.
  task automatic cycle();
    logic          acc, ot, stall;
    logic [OW-1:0] held;
    acc   = in_valid && in_ready && !rst;
    ot    = out_valid && out_ready && !rst;
    stall = out_valid && !out_ready && !rst;
    held  = out_data;
    if (ot) begin
      chk("sb_nonempty", OW'(sb.size() != 0), OW'(1));
      if (sb.size() != 0) chk("sb_data", out_data, sb.pop_front());
      n_out++;
    end
    if (acc) begin
      sb.push_back({model_tag, in_data});
      n_acc++;
    end
    if (rst) model_tag = 4'h0;
    else if (cfg_valid) model_tag = cfg_tag;
    @(posedge clk);
    #1;
    if (stall) begin
      chk("stall_valid", OW'(out_valid), OW'(1));
      chk("stall_data", out_data, held);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_tag = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; model_tag = 4'h0;
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    chk("rst_out_valid", OW'(out_valid), OW'(0));
    chk("rst_in_ready", OW'(in_ready), OW'(1));
    chk("rst_out_data", out_data, 36'h0);
    chk("rst_tag", OW'(tag_q), OW'(4'h0));

    // Basic tag insertion
    cfg_valid = 1'b1; cfg_tag = 4'hA;
    cycle();
    cfg_valid = 1'b0;
    chk("cfg_tag_q", OW'(tag_q), OW'(4'hA));
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("basic_valid", OW'(out_valid), OW'(1));
    chk("basic_data", out_data, 36'hA_DEAD_BEEF);
    cycle();
    chk("basic_drain", OW'(out_valid), OW'(0));

    // Backpressure and skid
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    cycle();
    chk("bp_ready1", OW'(in_ready), OW'(1));
    in_data = 32'h2;
    cycle();
    chk("bp_full_ready", OW'(in_ready), OW'(0));
    chk("bp_m_data", out_data, 36'hA_0000_0001);
    in_data = 32'h3;
    cycle();
    chk("bp_hold_ready", OW'(in_ready), OW'(0));
    out_ready = 1'b1;
    cycle();
    chk("bp_out2", out_data, 36'hA_0000_0002);
    chk("bp_ready_back", OW'(in_ready), OW'(1));
    cycle();
    in_valid = 1'b0;
    chk("bp_out3", out_data, 36'hA_0000_0003);
    chk("bp_valid3", OW'(out_valid), OW'(1));
    cycle();
    chk("bp_empty", OW'(out_valid), OW'(0));
    chk("bp_count", OW'(n_acc), OW'(4));

    // Tag change mid-stream: cfg coincides with acceptance of 0x12
    in_valid = 1'b1; in_data = 32'h10;
    cycle();
    chk("tc_10", out_data, 36'hA_0000_0010);
    in_data = 32'h11;
    cycle();
    chk("tc_11", out_data, 36'hA_0000_0011);
    in_data = 32'h12; cfg_valid = 1'b1; cfg_tag = 4'h5;
    cycle();
    cfg_valid = 1'b0;
    chk("tc_12", out_data, 36'hA_0000_0012);
    chk("tc_tag", OW'(tag_q), OW'(4'h5));
    in_data = 32'h13;
    cycle();
    in_valid = 1'b0;
    chk("tc_13", out_data, 36'h5_0000_0013);
    cycle();

    // Full throughput: 100 tokens back to back
    begin
      int out0;
      out0 = n_out;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
        in_data = 32'(i) + 32'h100;
        cycle();
        chk("tp_ready", OW'(in_ready), OW'(1));
        if (!out_valid || out_data !== {4'h5, 32'(i) + 32'h100})
          chk("tp_data", out_data, {4'h5, 32'(i) + 32'h100});
      end
      in_valid = 1'b0;
      cycle();
      chk("tp_outputs", OW'(n_out - out0), OW'(100));
      chk("tp_drained", OW'(out_valid), OW'(0));
    end

    // Reset mid-operation with buffer FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hAA;
    cycle();
    in_data = 32'hBB;
    cycle();
    chk("rm_full", OW'(in_ready), OW'(0));
    rst = 1'b1; in_data = 32'hCC;
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("rm_valid", OW'(out_valid), OW'(0));
    chk("rm_ready", OW'(in_ready), OW'(1));
    chk("rm_tag", OW'(tag_q), OW'(4'h0));
    chk("rm_data", out_data, 36'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rm_no_ghost", OW'(out_valid), OW'(0));
    end

    // Random stall with occasional tag changes
    begin
      int acc0, cyc;
      logic [DW-1:0] next_data;
      acc0 = n_acc;
      next_data = 32'h1000;
      cyc = 0;
      in_data = next_data;
      while ((n_acc - acc0) < 1000 && cyc < 20000) begin
        in_valid  = ($urandom_range(1) == 1);
        out_ready = ($urandom_range(1) == 1);
        cfg_valid = ($urandom_range(15) == 0);
        cfg_tag   = TW'($urandom_range(15));
        if (in_valid && in_ready) begin
          cycle();
          next_data = next_data + 32'd1;
          in_data = next_data;
        end else begin
          cycle();
        end
        chk("rnd_tag", OW'(tag_q), OW'(model_tag));
        cyc++;
      end
      chk("rnd_accepted", OW'(n_acc - acc0), OW'(1000));
      in_valid = 1'b0; cfg_valid = 1'b0; out_ready = 1'b1;
      cyc = 0;
      while (sb.size() != 0 && cyc < 10) begin
        cycle();
        cyc++;
      end
      chk("rnd_drained", OW'(sb.size()), OW'(0));
      cycle();
      chk("rnd_final_valid", OW'(out_valid), OW'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
